cpu_tick_sched: RTL and testbench

Clock-enable scheduler that sequences the processor's execution rate from the single 50 MHz board clock. It embeds a programmable tick divider and issues one-cycle `CPU_EN` pulses in one of three modes: free run (one pulse per divider period), single step (one pulse per button press), or burst (exactly N pulses at the divider rate, then hold). It sits between the board clock, the mode switches and step button, and the core's clock-enable input.

---
 rtl/cpu_tick_sched.sv | 231 +++++++++++++++++++++++
 tb/tb_cpu_tick_sched.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_tick_sched.sv
`default_nettype none
// ============================================================================
// Module   : cpu_tick_sched
// Purpose  : Clock-enable scheduler for the processor core. A programmable
//            tick divider paces one-cycle CPU_EN pulses in free-run, single
//            step (one pulse per button press) or burst (N pulses then hold)
//            mode, all from the single 50 MHz board clock.
// Ports    : CLK_50     - system clock, rising edge
//            RST        - asynchronous active-high reset
//            MODE[1:0]  - 00 halt, 01 run, 10 step, 11 burst
//            STEP_BTN   - raw asynchronous step button, active high
//            DIV_LD     - load DIV_VAL into the divider terminal register
//            DIV_VAL    - new divider terminal value (period = value + 1)
//            BURST_N    - burst pulse count, sampled on entry to burst
//            CPU_EN     - registered one-cycle enable pulse to the core
//            BUSY       - high while running or bursting
//            BURST_DONE - high while holding after a completed burst
// Options  : STEP_DEBOUNCE_EN - when defined, the synchronized step level
//            must be stable for DEB_CYC cycles before it is accepted.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_tick_sched #(
    parameter int CNT_W       = 26,
    parameter int DEFAULT_DIV = 50000000,
    parameter int DEB_CYC     = 1000000
) (
    input  logic             CLK_50,
    input  logic             RST,
    input  logic [1:0]       MODE,
    input  logic             STEP_BTN,
    input  logic             DIV_LD,
    input  logic [CNT_W-1:0] DIV_VAL,
    input  logic [7:0]       BURST_N,
    output logic             CPU_EN,
    output logic             BUSY,
    output logic             BURST_DONE
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_STEP  = 3'd2,
        S_BURST = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    localparam logic [1:0] c_mode_run   = 2'b01;
    localparam logic [1:0] c_mode_step  = 2'b10;
    localparam logic [1:0] c_mode_burst = 2'b11;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] w_div_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [7:0]       r_remain;
    logic [7:0]       w_remain_nxt;
    logic             w_en_nxt;
    logic             w_tc;

    // ------------------------------------------------------------------
    // Step button: 2-flop synchronizer, optional debounce, edge detect
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic r_step_prev;
    logic w_step_level;
    logic w_step_rise;

    always_ff @(posedge CLK_50 or posedge RST) begin
        if (RST) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_step_prev <= 1'b0;
        end else begin
            r_sync1     <= STEP_BTN;
            r_sync2     <= r_sync1;
            r_step_prev <= w_step_level;
        end
    end

`ifdef STEP_DEBOUNCE_EN
    localparam int c_deb_w = $clog2(DEB_CYC + 1);

    logic               r_step_acc;
    logic [c_deb_w-1:0] r_deb_cnt;

    // The accepted level flips only after the synchronized level has
    // disagreed with it on DEB_CYC consecutive cycles; any agreement
    // in between restarts the count.
    always_ff @(posedge CLK_50 or posedge RST) begin
        if (RST) begin
            r_step_acc <= 1'b0;
            r_deb_cnt  <= '0;
        end else if (r_sync2 == r_step_acc) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == c_deb_w'(DEB_CYC - 1)) begin
            r_step_acc <= r_sync2;
            r_deb_cnt  <= '0;
        end else begin
            r_deb_cnt <= r_deb_cnt + c_deb_w'(1);
        end
    end

    assign w_step_level = r_step_acc;
`else
    // Debounce disabled: DEB_CYC has no function in this build.
    logic w_deb_unused;
    assign w_deb_unused = (DEB_CYC > 0);
    assign w_step_level = r_sync2;
`endif

    assign w_step_rise = w_step_level & ~r_step_prev;

    // ------------------------------------------------------------------
    // Scheduler state machine
    // ------------------------------------------------------------------
    assign w_tc = (r_cnt == r_div);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_div_nxt    = r_div;
        w_remain_nxt = r_remain;
        w_en_nxt     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                case (MODE)
                    c_mode_run:  w_state_nxt = S_RUN;
                    c_mode_step: w_state_nxt = S_STEP;
                    c_mode_burst: begin
                        if (BURST_N != 8'd0) begin
                            w_state_nxt  = S_BURST;
                            w_remain_nxt = BURST_N;
                        end else begin
                            w_state_nxt = S_HOLD;
                        end
                    end
                    default: w_state_nxt = S_IDLE;
                endcase
            end

            S_RUN: begin
                // Leaving the mode beats a coincident terminal count.
                if (MODE != c_mode_run) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (DIV_LD) begin
                    w_cnt_nxt = '0;
                end else if (w_tc) begin
                    w_cnt_nxt = '0;
                    w_en_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            S_BURST: begin
                if (MODE != c_mode_burst) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (DIV_LD) begin
                    w_cnt_nxt = '0;
                end else if (w_tc) begin
                    w_cnt_nxt    = '0;
                    w_en_nxt     = 1'b1;
                    w_remain_nxt = r_remain - 8'd1;
                    if (r_remain == 8'd1) begin
                        w_state_nxt = S_HOLD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            S_STEP: begin
                w_cnt_nxt = '0;
                if (MODE != c_mode_step) begin
                    w_state_nxt = S_IDLE;
                end else if (w_step_rise) begin
                    w_en_nxt = 1'b1;
                end
            end

            S_HOLD: begin
                // Parked until the switch leaves burst, so a burst cannot
                // re-trigger while MODE stays at 11.
                w_cnt_nxt = '0;
                if (MODE != c_mode_burst) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // A divider load always restarts the period from zero.
        if (DIV_LD) begin
            w_div_nxt = DIV_VAL;
            w_cnt_nxt = '0;
        end
    end

    always_ff @(posedge CLK_50 or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_div      <= CNT_W'(DEFAULT_DIV);
            r_remain   <= 8'd0;
            CPU_EN     <= 1'b0;
            BUSY       <= 1'b0;
            BURST_DONE <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_div      <= w_div_nxt;
            r_remain   <= w_remain_nxt;
            CPU_EN     <= w_en_nxt;
            BUSY       <= (w_state_nxt == S_RUN) || (w_state_nxt == S_BURST);
            BURST_DONE <= (w_state_nxt == S_HOLD);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_tick_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_tick_sched
// Purpose  : Self-checking bench for cpu_tick_sched. A cycle-level reference
//            model derived from the mode rules predicts CPU_EN, BUSY and
//            BURST_DONE every cycle; directed scenarios add literal
//            expectations on pulse positions and counts, followed by a
//            randomized stimulus phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_tick_sched;

    localparam int CNT_W   = 26;
    localparam int DEF_DIV = 9;
    localparam int DEB     = 8;
`ifdef STEP_DEBOUNCE_EN
    localparam int LAT_EXTRA = DEB;
`else
    localparam int LAT_EXTRA = 0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_STEP  = 2;
    localparam int M_BURST = 3;
    localparam int M_HOLD  = 4;

    logic             CLK_50 = 1'b0;
    logic             RST = 1'b1;
    logic [1:0]       MODE = 2'b00;
    logic             STEP_BTN = 1'b0;
    logic             DIV_LD = 1'b0;
    logic [CNT_W-1:0] DIV_VAL = '0;
    logic [7:0]       BURST_N = 8'd0;
    logic             CPU_EN;
    logic             BUSY;
    logic             BURST_DONE;

    cpu_tick_sched #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEF_DIV),
        .DEB_CYC     (DEB)
    ) dut (
        .CLK_50     (CLK_50),
        .RST        (RST),
        .MODE       (MODE),
        .STEP_BTN   (STEP_BTN),
        .DIV_LD     (DIV_LD),
        .DIV_VAL    (DIV_VAL),
        .BURST_N    (BURST_N),
        .CPU_EN     (CPU_EN),
        .BUSY       (BUSY),
        .BURST_DONE (BURST_DONE)
    );

    always #5 CLK_50 = ~CLK_50;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input longint got, input longint want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, want);
    endtask

    // ------------------------------------------------------------------
    // Reference model: edge index arithmetic, button history vectors
    // ------------------------------------------------------------------
    longint      cyc    = 0;
    int          m_act  = M_IDLE;
    longint      m_t0   = 0;
    longint      m_div  = DEF_DIV;
    int          m_left = 0;
    logic [63:0] m_hist = '0;  // m_hist[j] = raw button sampled j edges ago
    logic [1:0]  m_acc  = '0;  // accepted step level after last two edges
    logic        exp_en = 1'b0;
    logic        m_stp;
    logic        m_anew;
    logic        m_alleq;
    longint      pulses[$];

    initial forever begin
        @(posedge CLK_50 or posedge RST);
        if (RST) begin
            m_act  = M_IDLE;
            m_t0   = 0;
            m_div  = DEF_DIV;
            m_left = 0;
            m_hist = '0;
            m_acc  = '0;
            exp_en = 1'b0;
        end else begin
            cyc++;
            m_stp  = m_acc[0] & ~m_acc[1];
            m_hist = {m_hist[62:0], STEP_BTN};
`ifdef STEP_DEBOUNCE_EN
            m_alleq = 1'b1;
            for (int j = 2; j <= DEB + 1; j++)
                if (m_hist[j] != m_hist[2]) m_alleq = 1'b0;
            m_anew = (m_alleq && (m_hist[2] != m_acc[0])) ? m_hist[2] : m_acc[0];
`else
            m_alleq = 1'b1;
            m_anew  = m_hist[1];
`endif
            m_acc  = {m_acc[0], m_anew};
            exp_en = 1'b0;
            case (m_act)
                M_IDLE: begin
                    if (MODE == 2'b01) begin m_act = M_RUN; m_t0 = cyc; end
                    else if (MODE == 2'b10) m_act = M_STEP;
                    else if (MODE == 2'b11) begin
                        if (BURST_N != 0) begin m_act = M_BURST; m_left = BURST_N; m_t0 = cyc; end
                        else m_act = M_HOLD;
                    end
                end
                M_RUN, M_BURST: begin
                    if (MODE != ((m_act == M_RUN) ? 2'b01 : 2'b11)) m_act = M_IDLE;
                    else if (DIV_LD) m_t0 = cyc;
                    else if (((cyc - m_t0) % (m_div + 1)) == 0) begin
                        exp_en = 1'b1;
                        if (m_act == M_BURST) begin
                            m_left--;
                            if (m_left == 0) m_act = M_HOLD;
                        end
                    end
                end
                M_STEP: begin
                    if (MODE != 2'b10) m_act = M_IDLE;
                    else if (m_stp) exp_en = 1'b1;
                end
                default: begin
                    if (MODE != 2'b11) m_act = M_IDLE;
                end
            endcase
            if (DIV_LD) m_div = DIV_VAL;
        end
    end

    // Per-cycle compare against the model
    initial forever begin
        @(negedge CLK_50);
        if (!RST) begin
            chk("cpu_en", CPU_EN, exp_en);
            chk("busy", BUSY, (m_act == M_RUN) || (m_act == M_BURST));
            chk("burst_done", BURST_DONE, m_act == M_HOLD);
            if (CPU_EN === 1'b1) pulses.push_back(cyc);
        end
    end

    task automatic tick();
        @(negedge CLK_50);
        #1;
    endtask

    longint e0;
    longint rise1;
    longint rise2;
    int     np;

    initial begin
        // ---------------- reset ----------------
        repeat (3) tick();
        chk("rst_cpu_en", CPU_EN, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", BURST_DONE, 0);
        RST = 1'b0;
        tick();
        chk("post_rst_busy", BUSY, 0);

        // ---------------- run, divider 3 ----------------
        MODE = 2'b01; DIV_LD = 1'b1; DIV_VAL = 3;
        e0 = cyc + 1;
        pulses.delete();
        tick();
        DIV_LD = 1'b0;
        repeat (20) tick();
        chk("run_count", pulses.size(), 5);
        chk("run_first", pulses[0], e0 + 4);
        for (int i = 1; i < pulses.size(); i++)
            chk("run_gap", pulses[i] - pulses[i-1], 4);
        chk("run_busy", BUSY, 1);

        // ---------------- burst of 5, divider 2 ----------------
        MODE = 2'b00; DIV_LD = 1'b1; DIV_VAL = 2;
        tick();
        DIV_LD = 1'b0;
        tick();
        MODE = 2'b11; BURST_N = 8'd5;
        e0 = cyc + 1;
        pulses.delete();
        repeat (30) tick();
        chk("burst_count", pulses.size(), 5);
        chk("burst_first", pulses[0], e0 + 3);
        chk("burst_last", pulses[4], e0 + 15);
        chk("burst_done_hi", BURST_DONE, 1);
        chk("burst_busy_lo", BUSY, 0);
        MODE = 2'b00;
        tick();
        chk("burst_done_lo", BURST_DONE, 0);

        // ---------------- step ----------------
        MODE = 2'b10;
        repeat (2) tick();
        pulses.delete();
        STEP_BTN = 1'b1; rise1 = cyc + 1;
        repeat (20) tick();
        STEP_BTN = 1'b0;
        repeat (10) tick();
        STEP_BTN = 1'b1; rise2 = cyc + 1;
        repeat (20) tick();
        STEP_BTN = 1'b0;
        repeat (15) tick();
        chk("step_count", pulses.size(), 2);
        chk("step_lat1", pulses[0], rise1 + 2 + LAT_EXTRA);
        chk("step_lat2", pulses[1], rise2 + 2 + LAT_EXTRA);
`ifdef STEP_DEBOUNCE_EN
        STEP_BTN = 1'b1;
        repeat (5) tick();
        STEP_BTN = 1'b0;
        repeat (20) tick();
        chk("glitch_none", pulses.size(), 2);
`endif
        MODE = 2'b00;
        repeat (2) tick();

        // ---------------- load on terminal count ----------------
        MODE = 2'b01; DIV_LD = 1'b1; DIV_VAL = 4;
        e0 = cyc + 1;
        pulses.delete();
        tick();
        DIV_LD = 1'b0;
        repeat (4) tick();
        DIV_LD = 1'b1; DIV_VAL = 1;
        tick();
        DIV_LD = 1'b0;
        repeat (5) tick();
        chk("ld_count", pulses.size(), 2);
        chk("ld_p0", pulses[0], e0 + 7);
        chk("ld_p1", pulses[1], e0 + 9);

        // ---------------- exit on terminal count ----------------
        MODE = 2'b00;
        repeat (2) tick();
        MODE = 2'b01; DIV_LD = 1'b1; DIV_VAL = 2;
        tick();
        DIV_LD = 1'b0;
        repeat (2) tick();
        MODE = 2'b00;
        pulses.delete();
        tick();
        chk("exit_nopulse", pulses.size(), 0);
        chk("exit_busy", BUSY, 0);
        repeat (5) tick();
        chk("exit_quiet", pulses.size(), 0);

        // ---------------- async reset mid-run ----------------
        MODE = 2'b01; DIV_LD = 1'b1; DIV_VAL = 1;
        tick();
        DIV_LD = 1'b0;
        repeat (3) tick();
        chk("pre_rst_busy", BUSY, 1);
        #2 RST = 1'b1;
        #1;
        chk("arst_cpu_en", CPU_EN, 0);
        chk("arst_busy", BUSY, 0);
        chk("arst_done", BURST_DONE, 0);
        MODE = 2'b00;
        tick();
        RST = 1'b0;
        tick();
        MODE = 2'b01;
        e0 = cyc + 1;
        pulses.delete();
        repeat (DEF_DIV + 2) tick();
        chk("rst_div_count", pulses.size(), 1);
        chk("rst_div_first", pulses[0], e0 + DEF_DIV + 1);
        MODE = 2'b00;
        tick();

        // ---------------- randomized ----------------
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 4) MODE = 2'($urandom_range(3));
            BURST_N = 8'($urandom_range(6));
            DIV_LD  = ($urandom_range(99) < 3);
            DIV_VAL = CNT_W'($urandom_range(5));
            if ($urandom_range(99) < 8) STEP_BTN = ~STEP_BTN;
            if (i % 1000 == 999) begin
                #2 RST = 1'b1;
                #1;
                chk("rnd_rst_en", CPU_EN, 0);
                chk("rnd_rst_busy", BUSY, 0);
                tick();
                RST = 1'b0;
            end
            tick();
        end
        DIV_LD = 1'b0;
        MODE = 2'b00;
        repeat (3) tick();

        np = n_pass;
        $display("%0d/%0d checks passed", np, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
